// File: rtl/change_payout_pkg.sv
// Shared types and constants for the change-payout controller.
// Amounts are counted in half-yuan units throughout.
package change_payout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        WAIT   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int unsigned HALF_UNITS = 32'd1;
    localparam int unsigned ONE_UNITS  = 32'd2;

endpackage

// File: rtl/change_payout_ack_timer.sv
// Ack-timeout counter: counts WAIT cycles without ack and flags the cycle
// on whose closing edge the strobe will have been high for TIMEOUT cycles.
module ack_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CW'(TIMEOUT))) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // The strobe rose one edge before counting began, hence TIMEOUT-1.
    assign expired = enable && (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/change_payout.sv
// Change-payout controller: pays an amount out as 1-yuan / 0.5-yuan coin
// strobes, largest coin first, with ack timeout and sticky fault.
module change_payout #(
    parameter int AMT_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             half_empty,
    input  logic             one_empty,
    input  logic             coin_ack,
    input  logic             clr,
    output logic             coin_half,
    output logic             coin_one,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);

    import change_payout_pkg::*;

    state_t           state_r, state_s;
    logic [AMT_W-1:0] remaining_r, remaining_s, rem_after_s;
    logic             coin_half_r, coin_half_s;
    logic             coin_one_r, coin_one_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             fault_r, fault_s;
    logic             timer_en_s, timer_clr_s, expired_s;

    assign timer_en_s  = (state_r == WAIT) && !coin_ack;
    assign timer_clr_s = (state_r != WAIT) || coin_ack;

    ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (timer_en_s),
        .clear   (timer_clr_s),
        .expired (expired_s)
    );

    // Only one strobe can be high, so it alone decides the coin value.
    assign rem_after_s = remaining_r - (coin_one_r ? AMT_W'(ONE_UNITS) : AMT_W'(HALF_UNITS));

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        coin_half_s = coin_half_r;
        coin_one_s  = coin_one_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        fault_s     = fault_r;
        case (state_r)
            IDLE: begin
                if (req && (amount != '0)) begin
                    remaining_s = amount;
                    busy_s      = 1'b1;
                    state_s     = SELECT;
                end else if (req) begin
                    done_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SELECT: begin
                if ((remaining_r >= AMT_W'(ONE_UNITS)) && !one_empty) begin
                    coin_one_s = 1'b1;
                    state_s    = WAIT;
                end else if ((remaining_r >= AMT_W'(HALF_UNITS)) && !half_empty) begin
                    coin_half_s = 1'b1;
                    state_s     = WAIT;
                end else begin
                    fault_s = 1'b1;
                    state_s = FAULT;
                end
            end
            WAIT: begin
                if (coin_ack) begin
                    coin_half_s = 1'b0;
                    coin_one_s  = 1'b0;
                    remaining_s = rem_after_s;
                    if (rem_after_s == '0) begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        state_s = SELECT;
                    end
                end else if (expired_s) begin
                    coin_half_s = 1'b0;
                    coin_one_s  = 1'b0;
                    fault_s     = 1'b1;
                    state_s     = FAULT;
                end else begin
                    state_s = WAIT;
                end
            end
            FAULT: begin
                if (clr) begin
                    fault_s     = 1'b0;
                    busy_s      = 1'b0;
                    remaining_s = '0;
                    state_s     = IDLE;
                end else begin
                    state_s = FAULT;
                end
            end
            default: begin
                state_s     = IDLE;
                remaining_s = '0;
                coin_half_s = 1'b0;
                coin_one_s  = 1'b0;
                busy_s      = 1'b0;
                fault_s     = 1'b0;
            end
        endcase
    end

    // State, remaining and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            coin_half_r <= 1'b0;
            coin_one_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            coin_half_r <= coin_half_s;
            coin_one_r  <= coin_one_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            fault_r     <= fault_s;
        end
    end

    assign coin_half = coin_half_r;
    assign coin_one  = coin_one_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fault     = fault_r;
    assign remaining = remaining_r;

endmodule

// File: tb/tb_change_payout.sv
// Bench for change_payout: directed table, hand sequences and random payouts
// checked against a greedy coin-selection model.
module tb_change_payout;

    localparam int AMT_W   = 3;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic             half_empty = 1'b0;
    logic             one_empty = 1'b0;
    logic             coin_ack = 1'b0;
    logic             clr = 1'b0;
    logic             coin_half, coin_one, busy, done, fault;
    logic [AMT_W-1:0] remaining;

    int checks = 0;
    int errors = 0;

    change_payout #(.AMT_W(AMT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .amount     (amount),
        .half_empty (half_empty),
        .one_empty  (one_empty),
        .coin_ack   (coin_ack),
        .clr        (clr),
        .coin_half  (coin_half),
        .coin_one   (coin_one),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amt;
        bit he;
        bit oe;
        int dly;
        int ones;
        int halves;
        bit flt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Greedy rule: value in half-units of the next coin, 0 when unpayable.
    function automatic int next_coin(input int rem, input bit he, input bit oe);
        if (rem >= 2 && !oe) return 2;
        if (rem >= 1 && !he) return 1;
        return 0;
    endfunction

    task automatic txn(input int amt, input bit he, input bit oe, input int dly,
                       input bit rnd, input bit poke,
                       output int n_one, output int n_half, output bit faulted);
        int rem, c, d;
        n_one = 0;
        n_half = 0;
        faulted = 1'b0;
        half_empty = he;
        one_empty = oe;
        amount = AMT_W'(amt);
        req = 1'b1;
        step();
        req = 1'b0;
        if (amt == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            step();
            chk("zero_done_pulse", done, 0);
            chk("zero_busy_after", busy, 0);
            return;
        end
        chk("accept_busy", busy, 1);
        chk("accept_rem", remaining, amt);
        chk("accept_done", done, 0);
        rem = amt;
        while (rem > 0 && !faulted) begin
            c = next_coin(rem, he, oe);
            step();
            if (c == 0) begin
                faulted = 1'b1;
                chk("select_fault", fault, 1);
                chk("select_fault_busy", busy, 1);
                chk("select_fault_strobe", {coin_one, coin_half}, 0);
            end else begin
                chk("coin_one", coin_one, (c == 2) ? 1 : 0);
                chk("coin_half", coin_half, (c == 1) ? 1 : 0);
                chk("strobe_rem", remaining, rem);
                if (coin_one) n_one++;
                if (coin_half) n_half++;
                d = dly;
                if (rnd) d = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
                for (int i = 0; i < d && i < TIMEOUT; i++) begin
                    if (poke) begin
                        req = 1'b1;
                        amount = AMT_W'($urandom);
                    end
                    step();
                    req = 1'b0;
                    if (i < TIMEOUT - 1) begin
                        chk("strobe_hold", coin_one | coin_half, 1);
                        chk("hold_no_fault", fault, 0);
                        chk("hold_rem", remaining, rem);
                    end
                end
                if (d >= TIMEOUT) begin
                    faulted = 1'b1;
                    chk("timeout_fault", fault, 1);
                    chk("timeout_strobe", coin_one | coin_half, 0);
                    chk("timeout_rem", remaining, rem);
                    chk("timeout_busy", busy, 1);
                end else begin
                    coin_ack = 1'b1;
                    step();
                    coin_ack = 1'b0;
                    rem -= c;
                    chk("ack_strobe_drop", coin_one | coin_half, 0);
                    chk("ack_rem", remaining, rem);
                    chk("ack_done", done, (rem == 0) ? 1 : 0);
                    chk("ack_busy", busy, (rem != 0) ? 1 : 0);
                end
            end
        end
        if (faulted) begin
            req = 1'b1;
            coin_ack = 1'b1;
            amount = AMT_W'(amt ^ 1);
            step();
            req = 1'b0;
            coin_ack = 1'b0;
            chk("fault_sticky", fault, 1);
            chk("fault_busy", busy, 1);
            chk("fault_rem_frozen", remaining, rem);
            chk("fault_no_strobe", {coin_one, coin_half}, 0);
            clr = 1'b1;
            step();
            clr = 1'b0;
            chk("clr_fault", fault, 0);
            chk("clr_busy", busy, 0);
            chk("clr_rem", remaining, 0);
            chk("clr_no_done", done, 0);
        end else begin
            step();
            chk("done_pulse", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int n1, nh;
        bit f;

        tbl[0] = '{3, 1'b0, 1'b0, 0,       1, 1, 1'b0};
        tbl[1] = '{4, 1'b0, 1'b1, 0,       0, 4, 1'b0};
        tbl[2] = '{1, 1'b1, 1'b0, 0,       0, 0, 1'b1};
        tbl[3] = '{2, 1'b0, 1'b0, TIMEOUT, 1, 0, 1'b1};
        tbl[4] = '{2, 1'b0, 1'b0, 0,       1, 0, 1'b0};
        tbl[5] = '{0, 1'b0, 1'b0, 0,       0, 0, 1'b0};
        tbl[6] = '{7, 1'b0, 1'b0, 3,       3, 1, 1'b0};
        tbl[7] = '{3, 1'b1, 1'b0, 1,       1, 0, 1'b1};
        tbl[8] = '{5, 1'b1, 1'b1, 0,       0, 0, 1'b1};
        tbl[9] = '{7, 1'b0, 1'b1, 2,       0, 7, 1'b0};

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {coin_one, coin_half}, 0);
        chk("rst_done_fault", {done, fault}, 0);
        chk("rst_rem", remaining, 0);
        #4 rst = 1'b1;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_in_idle", {busy, fault, done}, 0);

        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].amt, tbl[i].he, tbl[i].oe, tbl[i].dly, 1'b0, (i == 6), n1, nh, f);
            chk($sformatf("tbl%0d_ones", i), n1, tbl[i].ones);
            chk($sformatf("tbl%0d_halves", i), nh, tbl[i].halves);
            chk($sformatf("tbl%0d_fault", i), f, tbl[i].flt);
        end

        // Asynchronous reset in the middle of a WAIT.
        half_empty = 1'b0;
        one_empty = 1'b0;
        amount = AMT_W'(5);
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("pre_rst_strobe", coin_one, 1);
        step();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_strobes", {coin_one, coin_half}, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rem", remaining, 0);
        chk("async_rst_flags", {done, fault}, 0);
        #2 rst = 1'b1;
        step();
        txn(1, 1'b0, 1'b0, 0, 1'b0, 1'b0, n1, nh, f);
        chk("post_rst_halves", nh, 1);
        chk("post_rst_ones", n1, 0);

        for (int t = 0; t < 40; t++) begin
            txn(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 0, 1'b1, 1'b1, n1, nh, f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/change_payout.md
# change_payout

Change-payout controller on the output side of the vending machine. It accepts a change amount from the vending FSM and pays it out as individual coin strobes to two coin hoppers: 0.5-yuan and 1-yuan. Each coin uses a strobe/ack handshake with an ack timeout. The largest coin is always preferred. An empty 1-yuan hopper falls back to half coins; when the amount cannot be paid, the block faults.

## Interface
Parameters:
- AMT_W, 3, width of amount in half-yuan units (max payout (2^AMT_W - 1) × 0.5 yuan)
- TIMEOUT, 8, cycles a coin strobe may wait for ack before fault (≥ 2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  1  payout request, sampled on clk; honoured only when busy=0
- amount  input  AMT_W  change in half-yuan units, sampled with req
- half_empty  input  1  0.5-yuan hopper empty (level)
- one_empty  input  1  1-yuan hopper empty (level)
- coin_ack  input  1  hopper has ejected the currently strobed coin
- clr  input  1  clears FAULT
- coin_half  output  1  eject one 0.5-yuan coin; held until acked
- coin_one  output  1  eject one 1-yuan coin; held until acked
- busy  output  1  payout or fault in progress
- done  output  1  one-cycle pulse: payout complete
- fault  output  1  payout aborted; remains high until clr
- remaining  output  AMT_W  half-units still owed

## Operation
- All outputs registered. Reset value of every output: 0. State after reset: IDLE, remaining=0.
- States: IDLE, SELECT, WAIT, FAULT.
- IDLE, req=1, amount≠0:
  - remaining←amount, busy←1, go SELECT.
- IDLE, req=1, amount=0:
  - done←1 for one cycle, busy stays 0, stay IDLE.
- req while busy=1: ignored, not queued.
- SELECT (exactly one cycle) picks the next coin:
  - remaining ≥ 2 and one_empty=0: coin_one←1, go WAIT.
  - Otherwise, remaining ≥ 1 and half_empty=0: coin_half←1, go WAIT.
  - Otherwise: go FAULT.
- WAIT:
  - coin_ack=1 sampled: drop the strobe, remaining -= 2 (one) or 1 (half), timer cleared.
  - If the new remaining = 0: done←1, busy←0, go IDLE.
  - Else go SELECT.
- WAIT timeout: the strobe has been high for TIMEOUT cycles with no ack → strobe←0, fault←1, go FAULT. remaining is not decremented.
- FAULT:
  - busy=1, fault=1, strobes 0, remaining frozen, req ignored, coin_ack ignored.
  - clr=1 → IDLE, fault←0, busy←0, remaining←0; no done.
- clr outside FAULT: no effect.
- At most one strobe is high at any time; coin_half and coin_one are never high together.
- Arithmetic: remaining never underflows, because a one-coin is only chosen when remaining ≥ 2.
- Hopper empty flags are evaluated only in SELECT; a change during WAIT does not affect the coin already strobed.
- Reset mid-payout (any state): all outputs and remaining to 0 immediately (asynchronous), state IDLE; the partial payout is lost.

## Timing
- req sampled at edge E0 → busy=1 after E0 → strobe high after E1.
- Each coin costs one SELECT cycle plus its WAIT cycles.
- With ack on the first WAIT cycle, done rises after edge E(2n) for an n-coin payout.
- Ack sampled on the same edge the strobe rises is not possible: strobe and ack are registered on separate edges.
- Ack sampled in the first WAIT cycle counts as valid.
- Timeout: strobe rises after Ek; with no ack, fault=1 after edge E(k+TIMEOUT).
- done and busy fall on the same edge. A new req is accepted on the edge following done.

## Structure
- Package change_payout_pkg holds:
  - state encoding constants IDLE/SELECT/WAIT/FAULT;
  - coin values HALF_UNITS=1 and ONE_UNITS=2 in half-yuan units.
- Sub-module ack_timer, a $clog2(TIMEOUT+1)-bit counter:
  - inputs: clk, rst, enable (WAIT with no ack), clear;
  - output: expired.
- Top level holds the FSM, the remaining register and the output registers.

## Test plan
- amount=3, both hoppers full, ack one cycle after each strobe → coin_one then coin_half, remaining 3→1→0, done pulses once, busy falls with done.
- amount=4, one_empty=1 → four coin_half strobes, no coin_one, done after the 4th ack.
- amount=1, half_empty=1 → no strobe, fault=1 two cycles after req, busy=1; clr → fault=0, busy=0, no done.
- amount=2, ack withheld → coin_one high exactly TIMEOUT cycles, then fault=1, remaining=2; clr recovers; a new req amount=2 with ack completes normally.
- req with amount=0 → done pulse after one edge, busy never rises. req while busy is ignored (remaining unchanged).
- rst low mid-WAIT during amount=5 → all outputs 0 asynchronously. After release, a new req amount=1 pays one half coin.
